// File: rtl/ehr_fill_ctrl_pkg.sv
// Shared EHR definitions: FSM encoding, EHR geometry and the EHR_DATAn register addresses.
// EHR geometry follows the EHR_192_BITS_EN macro (192 bits when defined, 128 otherwise).
package ehr_fill_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2,
    ST_ERROR = 2'd3
  } ehr_state_e;

`ifdef EHR_192_BITS_EN
  localparam int EHR_BITS  = 192;
  localparam int EHR_WORDS = 6;
`else
  localparam int EHR_BITS  = 128;
  localparam int EHR_WORDS = 4;
`endif

  localparam logic [7:0] EHR_BITS_C = 8'(EHR_BITS);
  localparam logic [7:0] WORD_BITS  = 8'd16;

  // Shared with the RNG register map; one word every 4 bytes.
  localparam logic [11:0] EHR_DATA0 = 12'h114;
  localparam logic [11:0] EHR_DATA1 = 12'h118;
  localparam logic [11:0] EHR_DATA2 = 12'h11C;
  localparam logic [11:0] EHR_DATA3 = 12'h120;
  localparam logic [11:0] EHR_DATA4 = 12'h124;
  localparam logic [11:0] EHR_DATA5 = 12'h128;

  localparam logic [5:0][11:0] EHR_DATA_ADDR =
    {EHR_DATA5, EHR_DATA4, EHR_DATA3, EHR_DATA2, EHR_DATA1, EHR_DATA0};

endpackage

// File: rtl/ehr_fill_ctrl_if.sv
// Entropy-source, CPU-read and status signals of the EHR fill controller.
interface ehr_fill_ctrl_if;
  logic        rnd_src_en;
  logic        crngt_valid;
  logic        collector_valid;
  logic        trng_crngt_bypass;
  logic        curr_test_err;
  logic        rst_trng_logic;
  logic        cpu_ehr_rd;
  logic [11:0] cpu_rng_paddr;
  logic        ehr_wr_en;
  logic [7:0]  bits_counter;
  logic        ehr_valid;
  logic        ehr_clr;
  logic        ehr_valid_int;
  logic        err_int;
  logic [2:0]  err_cnt;
  logic [1:0]  ehr_state;

  modport master (
    output rnd_src_en, crngt_valid, collector_valid, trng_crngt_bypass,
           curr_test_err, rst_trng_logic, cpu_ehr_rd, cpu_rng_paddr,
    input  ehr_wr_en, bits_counter, ehr_valid, ehr_clr, ehr_valid_int,
           err_int, err_cnt, ehr_state
  );

  modport slave (
    input  rnd_src_en, crngt_valid, collector_valid, trng_crngt_bypass,
           curr_test_err, rst_trng_logic, cpu_ehr_rd, cpu_rng_paddr,
    output ehr_wr_en, bits_counter, ehr_valid, ehr_clr, ehr_valid_int,
           err_int, err_cnt, ehr_state
  );
endinterface

// File: rtl/ehr_rd_tracker.sv
// EHR_DATAn address decode and read mask; all_read flags the read that completes the set.
module ehr_rd_tracker
  import ehr_fill_ctrl_pkg::*;
(
  input  logic        rng_clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        rd,
  input  logic [11:0] paddr,
  output logic        all_read
);

  logic [EHR_WORDS-1:0] mask, hit;

  for (genvar n = 0; n < EHR_WORDS; n++) begin : g_dec
    assign hit[n] = (paddr == EHR_DATA_ADDR[n]);
  end

  assign all_read = rd && (|hit) && (&(mask | hit));

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n)   mask <= '0;
    else if (clr) mask <= '0;
    else if (rd)  mask <= mask | hit;
  end

endmodule

// File: rtl/ehr_fill_ctrl.sv
// EHR fill sequencer: gates entropy writes, counts bits, tracks CPU reads, locks out on errors.
// EHR size selected by the EHR_192_BITS_EN macro (see ehr_fill_ctrl_pkg).
module ehr_fill_ctrl
  import ehr_fill_ctrl_pkg::*;
#(
  parameter int ERR_LIMIT = 4
) (
  input  logic          rng_clk,
  input  logic          rst_n,
  ehr_fill_ctrl_if.slave bus
);

  ehr_state_e state;
  logic [7:0] bits_q, bits_nxt;
  logic [2:0] err_cnt_q, err_nxt;
  logic       valid_q, clr_q, vint_q, err_int_q;
  logic       wr, err_hit, rd_full, rd_done, trk_clr;

  assign bus.ehr_wr_en     = (state == ST_FILL);
  assign bus.bits_counter  = bits_q;
  assign bus.ehr_valid     = valid_q;
  assign bus.ehr_clr       = clr_q;
  assign bus.ehr_valid_int = vint_q;
  assign bus.err_int       = err_int_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.ehr_state     = state;

  assign wr       = (state == ST_FILL) &&
                    (bus.crngt_valid || (bus.collector_valid && bus.trng_crngt_bypass));
  assign err_hit  = bus.curr_test_err && (state == ST_FILL || state == ST_FULL);
  assign rd_full  = bus.cpu_ehr_rd && (state == ST_FULL);
  assign bits_nxt = bits_q + WORD_BITS;
  assign err_nxt  = (err_cnt_q == 3'd7) ? 3'd7 : err_cnt_q + 3'd1;
  // Every path that restarts the fill also wipes the read mask in the same cycle.
  assign trk_clr  = bus.rst_trng_logic || err_hit || rd_done;

  ehr_rd_tracker u_rd_tracker (
    .rng_clk  (rng_clk),
    .rst_n    (rst_n),
    .clr      (trk_clr),
    .rd       (rd_full),
    .paddr    (bus.cpu_rng_paddr),
    .all_read (rd_done)
  );

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bits_q    <= '0;
      err_cnt_q <= '0;
      valid_q   <= 1'b0;
      clr_q     <= 1'b0;
      vint_q    <= 1'b0;
      err_int_q <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      vint_q <= 1'b0;
      if (bus.rst_trng_logic) begin
        state     <= ST_IDLE;
        bits_q    <= '0;
        err_cnt_q <= '0;
        valid_q   <= 1'b0;
        clr_q     <= 1'b1;
        err_int_q <= 1'b0;
      end else if (err_hit) begin
        bits_q    <= '0;
        valid_q   <= 1'b0;
        clr_q     <= 1'b1;
        err_cnt_q <= err_nxt;
        if (err_nxt == 3'(ERR_LIMIT)) begin
          state     <= ST_ERROR;
          err_int_q <= 1'b1;
        end else begin
          state <= ST_FILL;
        end
      end else begin
        case (state)
          ST_IDLE: if (bus.rnd_src_en) state <= ST_FILL;
          ST_FILL: begin
            // A write accepted while enable drops is still counted so the
            // counter stays aligned with the EHR contents.
            if (wr) bits_q <= bits_nxt;
            if (wr && bits_nxt == EHR_BITS_C) begin
              state     <= ST_FULL;
              valid_q   <= 1'b1;
              vint_q    <= 1'b1;
              err_cnt_q <= '0;
            end else if (!bus.rnd_src_en) begin
              state <= ST_IDLE;
            end
          end
          ST_FULL: if (rd_done) begin
            bits_q  <= '0;
            valid_q <= 1'b0;
            clr_q   <= 1'b1;
            state   <= bus.rnd_src_en ? ST_FILL : ST_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ehr_fill_ctrl.sv
// Directed bench for ehr_fill_ctrl: pulse events (ehr_clr / ehr_valid_int) go through a scoreboard.
module tb_ehr_fill_ctrl;

`ifdef EHR_192_BITS_EN
  localparam int NW = 12;
  localparam int NR = 6;
`else
  localparam int NW = 8;
  localparam int NR = 4;
`endif
  localparam int FULLB = NW * 16;

  typedef struct packed {
    logic       clr;
    logic       vint;
    logic [7:0] bits;
    logic [1:0] st;
    logic [2:0] ec;
  } ev_t;

  logic rng_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  ev_t  sbq[$];
  logic [11:0] addr [6];

  ehr_fill_ctrl_if bus();

  ehr_fill_ctrl #(.ERR_LIMIT(4)) dut (
    .rng_clk (rng_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #5 rng_clk = ~rng_clk;

  task automatic step();
    @(posedge rng_clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic push(input logic clr, input logic vint, input int bits,
                      input int st, input int ec);
    ev_t e;
    e.clr = clr; e.vint = vint; e.bits = 8'(bits); e.st = 2'(st); e.ec = 3'(ec);
    sbq.push_back(e);
  endtask

  task automatic wr1();
    bus.crngt_valid = 1'b1;
    step();
    bus.crngt_valid = 1'b0;
  endtask

  task automatic rd1(input logic [11:0] a);
    bus.cpu_rng_paddr = a;
    bus.cpu_ehr_rd    = 1'b1;
    step();
    bus.cpu_ehr_rd    = 1'b0;
  endtask

  task automatic err1();
    bus.curr_test_err = 1'b1;
    step();
    bus.curr_test_err = 1'b0;
  endtask

  // Monitor: every clr / valid_int pulse must match the next queued expectation.
  initial begin
    ev_t got, exp;
    forever begin
      @(negedge rng_clk);
      if (rst_n && (bus.ehr_clr || bus.ehr_valid_int)) begin
        got = {bus.ehr_clr, bus.ehr_valid_int, bus.bits_counter, bus.ehr_state, bus.err_cnt};
        n_chk++;
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL sb_event unexpected got=%h exp=none", got);
        end else begin
          exp = sbq.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL sb_event got=%h exp=%h", got, exp);
          end
        end
      end
    end
  end

  initial begin
    for (int n = 0; n < 6; n++) addr[n] = 12'h114 + 12'(4 * n);
    bus.rnd_src_en = 0; bus.crngt_valid = 0; bus.collector_valid = 0;
    bus.trng_crngt_bypass = 0; bus.curr_test_err = 0; bus.rst_trng_logic = 0;
    bus.cpu_ehr_rd = 0; bus.cpu_rng_paddr = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_state", int'(bus.ehr_state), 0);
    chk("rst_bits", int'(bus.bits_counter), 0);
    chk("rst_valid", int'(bus.ehr_valid), 0);
    chk("rst_wr_en", int'(bus.ehr_wr_en), 0);
    chk("rst_err", int'({bus.err_int, bus.err_cnt}), 0);

    // Fill with CRNGT words
    bus.rnd_src_en = 1'b1;
    step();
    chk("fill_state", int'(bus.ehr_state), 1);
    chk("fill_wr_en", int'(bus.ehr_wr_en), 1);
    for (int i = 1; i <= NW; i++) begin
      if (i == NW) push(0, 1, FULLB, 2, 0);
      wr1();
      chk("fill_bits", int'(bus.bits_counter), 16 * i);
    end
    chk("full_valid", int'(bus.ehr_valid), 1);
    chk("full_state", int'(bus.ehr_state), 2);
    wr1();
    chk("full_blocked_bits", int'(bus.bits_counter), FULLB);
    chk("full_wr_en", int'(bus.ehr_wr_en), 0);

    // Reads: foreign address, repeats, then the completing read
    rd1(12'h000);
    rd1(addr[0]); rd1(addr[1]); rd1(addr[1]);
    for (int n = 2; n < NR - 1; n++) rd1(addr[n]);
    chk("partial_rd_valid", int'(bus.ehr_valid), 1);
    chk("partial_rd_bits", int'(bus.bits_counter), FULLB);
    push(1, 0, 0, 1, 0);
    rd1(addr[NR-1]);
    chk("rd_done_valid", int'(bus.ehr_valid), 0);
    chk("rd_done_state", int'(bus.ehr_state), 1);

    // Bypass fill starting the very next cycle
    bus.trng_crngt_bypass = 1'b1;
    for (int i = 1; i <= NW; i++) begin
      if (i == NW) push(0, 1, FULLB, 2, 0);
      bus.collector_valid = 1'b1;
      step();
      bus.collector_valid = 1'b0;
      chk("byp_bits", int'(bus.bits_counter), 16 * i);
    end
    for (int n = 0; n < NR - 1; n++) rd1(addr[n]);
    push(1, 0, 0, 1, 0);
    rd1(addr[NR-1]);
    bus.trng_crngt_bypass = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.collector_valid = 1'b1;
      step();
      bus.collector_valid = 1'b0;
    end
    chk("no_byp_bits", int'(bus.bits_counter), 0);

    // Consecutive errors up to the limit
    wr1(); wr1();
    for (int k = 1; k <= 4; k++) begin
      push(1, 0, 0, (k == 4) ? 3 : 1, k);
      err1();
      chk("err_cnt", int'(bus.err_cnt), k);
      chk("err_bits", int'(bus.bits_counter), 0);
      if (k < 4) wr1();
    end
    chk("err_state", int'(bus.ehr_state), 3);
    chk("err_int", int'(bus.err_int), 1);
    chk("err_wr_en", int'(bus.ehr_wr_en), 0);
    err1();
    chk("err_ignored", int'(bus.err_cnt), 4);
    wr1();
    chk("err_blocked_bits", int'(bus.bits_counter), 0);
    push(1, 0, 0, 0, 0);
    bus.rst_trng_logic = 1'b1;
    step();
    bus.rst_trng_logic = 1'b0;
    chk("soft_rst_state", int'(bus.ehr_state), 0);
    chk("soft_rst_err", int'({bus.err_int, bus.err_cnt}), 0);
    step();
    chk("restart_state", int'(bus.ehr_state), 1);

    // Error coincident with the final write
    for (int i = 1; i < NW; i++) wr1();
    push(1, 0, 0, 1, 1);
    bus.crngt_valid = 1'b1; bus.curr_test_err = 1'b1;
    step();
    bus.crngt_valid = 1'b0; bus.curr_test_err = 1'b0;
    chk("coinc_wr_bits", int'(bus.bits_counter), 0);
    chk("coinc_wr_valid", int'(bus.ehr_valid), 0);
    chk("coinc_wr_errcnt", int'(bus.err_cnt), 1);
    for (int i = 1; i <= NW; i++) begin
      if (i == NW) push(0, 1, FULLB, 2, 0);
      wr1();
    end
    chk("full_clears_errcnt", int'(bus.err_cnt), 0);

    // Error coincident with the final read
    for (int n = 0; n < NR - 1; n++) rd1(addr[n]);
    push(1, 0, 0, 1, 1);
    bus.curr_test_err = 1'b1;
    rd1(addr[NR-1]);
    bus.curr_test_err = 1'b0;
    chk("coinc_rd_state", int'(bus.ehr_state), 1);
    chk("coinc_rd_errcnt", int'(bus.err_cnt), 1);
    step();

    // Enable drop keeps the count
    wr1(); wr1();
    bus.rnd_src_en = 1'b0;
    step();
    chk("en_drop_state", int'(bus.ehr_state), 0);
    wr1();
    chk("en_drop_bits", int'(bus.bits_counter), 32);
    bus.rnd_src_en = 1'b1;
    step();
    wr1();
    chk("en_resume_bits", int'(bus.bits_counter), 48);

    // Asynchronous reset mid-fill
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bits", int'(bus.bits_counter), 0);
    chk("arst_state", int'(bus.ehr_state), 0);
    chk("arst_errcnt", int'(bus.err_cnt), 0);
    rst_n = 1'b1;
    step(); step();
    chk("sb_drain", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
